// File: rtl/polar_encoder.sv
// Polar encoder: x = u * F^{(x)n}, F = [[1,0],[1,1]], N in {128, 256, 512}.
// Bits are loaded serially, transformed in place with one butterfly stage per
// cycle, then streamed out in natural order under a valid/ready handshake.
module polar_encoder #(
    parameter int unsigned NMAX = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] n_sel,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_frozen,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    localparam int unsigned IW = $clog2(NMAX);
    localparam int unsigned CW = $clog2(NMAX + 1);
    localparam int unsigned SW = $clog2(IW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ENC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NMAX-1:0] bits_q, bits_d;
    logic [NMAX-1:0] stage_out;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   lg_q, lg_d;
    logic [SW-1:0]   stg_q, stg_d;
    logic [IW-1:0]   j_q, j_d;
    logic [CW-1:0]   n_val, n_val_d;

    logic            in_ready_d;
    logic            out_valid_d;
    logic            out_bit_d;
    logic            out_last_d;
    logic            busy_d;

    // Current and next code length from the latched log2(N).
    assign n_val   = CW'(1) << lg_q;
    assign n_val_d = CW'(1) << lg_d;

    // One butterfly stage: buf[k] ^= buf[k + 2^s] for every k with bit s clear.
    // Bits at N and above are zero, so applying it across the whole buffer is harmless.
    always_comb begin
        logic [IW-1:0] stride;
        logic [IW-1:0] ki;
        stage_out = bits_q;
        stride    = IW'(1) << stg_q;
        ki        = '0;
        for (int unsigned k = 0; k < NMAX; k++) begin
            ki = IW'(k);
            if ((ki & stride) == '0) begin
                stage_out[ki] = bits_q[ki] ^ bits_q[ki | stride];
            end
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        cnt_d   = cnt_q;
        lg_d    = lg_q;
        stg_d   = stg_q;
        j_d     = j_q;

        case (state_q)
            IDLE: begin
                if (start && (n_sel != 2'd3)) begin
                    state_d = LOAD;
                    lg_d    = SW'(7) + SW'(n_sel);
                    bits_d  = '0;
                    cnt_d   = '0;
                    stg_d   = '0;
                    j_d     = '0;
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    bits_d[cnt_q[IW-1:0]] = in_bit & ~in_frozen;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == n_val - CW'(1)) begin
                        state_d = ENC;
                        stg_d   = '0;
                    end
                end
            end
            ENC: begin
                bits_d = stage_out;
                if (stg_q == lg_q - SW'(1)) begin
                    state_d = OUT;
                    j_d     = '0;
                end else begin
                    stg_d = stg_q + SW'(1);
                end
            end
            OUT: begin
                if (out_valid && out_ready) begin
                    if (CW'(j_q) == n_val - CW'(1)) begin
                        state_d = IDLE;
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == LOAD) && (cnt_d < n_val_d);
        out_valid_d = (state_d == OUT);
        out_bit_d   = (state_d == OUT) ? bits_d[j_d] : 1'b0;
        out_last_d  = (state_d == OUT) && (CW'(j_d) == n_val_d - CW'(1));
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bits_q    <= '0;
            cnt_q     <= '0;
            lg_q      <= '0;
            stg_q     <= '0;
            j_q       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bits_q    <= bits_d;
            cnt_q     <= cnt_d;
            lg_q      <= lg_d;
            stg_q     <= stg_d;
            j_q       <= j_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_bit   <= out_bit_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder against a subset-sum reference model.
module tb_polar_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] n_sel = 2'd0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_frozen = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int hs_cyc = 0;

    logic [511:0] u;
    logic [511:0] fz;
    logic [511:0] expv;

    polar_encoder #(.NMAX(512)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_sel     (n_sel),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_frozen (in_frozen),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Cycle index used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // x[j] = XOR of u_eff[i] over every i whose bit set contains j's bits.
    function automatic logic [511:0] ref_enc(input int n, input logic [511:0] uu,
                                             input logic [511:0] ff);
        logic [511:0] x;
        x = '0;
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < n; i++) begin
                if ((i & j) == j) x[j] = x[j] ^ (uu[i] & ~ff[i]);
            end
        end
        return x;
    endfunction

    task automatic do_start(input logic [1:0] ns);
        n_sel = ns;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, 1);
        check("start_out_valid", out_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_load(input int n, input bit gaps);
        int  i = 0;
        int  budget = 0;
        bit  hs;
        while (i < n && budget < 5000) begin
            in_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_bit    = u[i];
            in_frozen = fz[i];
            @(negedge clk);
            check("load_in_ready", in_ready, 1);
            hs = in_valid && in_ready;
            if (hs) hs_cyc = cyc;
            @(posedge clk); #1;
            budget++;
            if (hs) i++;
        end
        in_valid = 1'b0;
        check("load_count", i, n);
    endtask

    task automatic do_collect(input int n, input int lg, input bit rnd_ready,
                              input bit inj_enc, input bit inj_last);
        int j = 0;
        int budget = 0;
        bit first = 1'b1;
        bit stalled = 1'b0;
        logic pbit = 1'b0;
        logic plast = 1'b0;
        while (j < n && budget < 5000) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = 1'b0;
            if (inj_enc && budget == 0) begin
                start = 1'b1;
                n_sel = 2'd2;
            end
            if (inj_last && j == n - 1) begin
                out_ready = 1'b1;
                start = 1'b1;
                n_sel = 2'd0;
            end
            @(negedge clk);
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_bit", out_bit, pbit);
                check("stall_last", out_last, plast);
            end
            if (out_valid) begin
                if (first) begin
                    check("latency", cyc - hs_cyc, lg + 1);
                    first = 1'b0;
                end
                check("x_bit", out_bit, expv[j]);
                check("x_last", out_last, (j == n - 1));
                pbit = out_bit;
                plast = out_last;
                stalled = !out_ready;
                if (out_ready) j++;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("handshakes", j, n);
        @(negedge clk);
        check("done_valid", out_valid, 0);
        check("done_busy", busy, 0);
        check("done_last", out_last, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_cw(input logic [1:0] ns, input bit gaps, input bit rnd_ready,
                          input bit inj_enc, input bit inj_last);
        int n = 128 << ns;
        int lg = 7 + int'(ns);
        expv = ref_enc(n, u, fz);
        do_start(ns);
        do_load(n, gaps);
        do_collect(n, lg, rnd_ready, inj_enc, inj_last);
    endtask

    initial begin
        // Reset state.
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // N=128, everything frozen with in_bit=1: all-zero codeword.
        u = '1; fz = '1;
        run_cw(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // N=512, only u[511]=1: all ones.
        u = '0; fz = '0; u[511] = 1'b1;
        run_cw(2'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // N=256, u[0] only, then u[1] only.
        u = '0; fz = '0; u[0] = 1'b1;
        run_cw(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        u = '0; fz = '0; u[1] = 1'b1;
        run_cw(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // N=128 random message and frozen mask, random stalls on both sides.
        u = '0; fz = '0;
        for (int i = 0; i < 128; i++) begin
            u[i]  = 1'($urandom_range(0, 1));
            fz[i] = 1'($urandom_range(0, 1));
        end
        run_cw(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reserved n_sel: start ignored, stray in_valid has no effect.
        n_sel = 2'd3; start = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("nsel3_busy", busy, 0);
            check("nsel3_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // N=256 random, start pulsed during ENC and on the final handshake.
        u = '0; fz = '0;
        for (int i = 0; i < 256; i++) begin
            u[i]  = 1'($urandom_range(0, 1));
            fz[i] = 1'($urandom_range(0, 3) == 0);
        end
        run_cw(2'd1, 1'b0, 1'b1, 1'b1, 1'b1);

        // Reset pulsed in the middle of ENC.
        u = '0; fz = '0; u[5] = 1'b1;
        do_start(2'd0);
        do_load(128, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_bit", out_bit, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("post_rst_idle_busy", busy, 0);
            check("post_rst_idle_valid", out_valid, 0);
            @(posedge clk); #1;
        end

        // Fresh N=128 run after reset with u[127]=1: all ones.
        u = '0; fz = '0; u[127] = 1'b1;
        run_cw(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/polar_encoder.md
POLAR_ENCODER -- requirements
Module: polar_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n respectively.
REQ-002 Parameter NMAX, default 512, meaning the maximum code length; the block SHALL support N in {128, 256, 512}.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a codeword when the block is idle.
REQ-006 n_sel  input  2  code length select: 0=128, 1=256, 2=512, 3=reserved; sampled at start.
REQ-007 in_valid  input  1  in_bit/in_frozen are valid this cycle.
REQ-008 in_bit  input  1  message bit u[i], supplied in index order i=0..N-1.
REQ-009 in_frozen  input  1  marks position i as frozen; 1 forces u[i]=0 regardless of in_bit.
REQ-010 in_ready  output  1  block accepts an input bit this cycle.
REQ-011 out_valid  output  1  out_bit is a valid codeword bit.
REQ-012 out_bit  output  1  codeword bit x[j], j=0..N-1 in natural order.
REQ-013 out_last  output  1  high together with out_valid on x[N-1].
REQ-014 out_ready  input  1  downstream accepts out_bit this cycle.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, ENC and OUT.
REQ-017 IDLE->LOAD on start=1 with n_sel!=3; the block SHALL latch N and clear the 512-bit buffer and the index counter.
REQ-018 start SHALL be ignored when n_sel=3 and in every state other than IDLE.
REQ-019 In LOAD, in_ready=1; on in_valid&in_ready, the block SHALL store buf[i]=in_bit&~in_frozen and increment i.
REQ-020 In LOAD, in_ready SHALL be low only when the counter has already reached N; it is never held low otherwise.
REQ-021 The handshake accepting i=N-1 SHALL move the FSM to ENC on the next edge.
REQ-022 ENC SHALL run exactly log2(N) cycles (7/8/9), using stage counter s=0..log2(N)-1.
REQ-023 On each ENC cycle, the block SHALL update buf[k] to buf[k]^buf[k+2^s] for every k<N whose bit s is 0; other bits are unchanged.
REQ-024 Net result: x = u·F^{⊗n}, F=[[1,0],[1,1]], natural order, no bit reversal.
REQ-025 Bits of buf at index N and above SHALL remain 0 and SHALL NOT affect the result.
REQ-026 After the last ENC stage, the FSM SHALL enter OUT with output index j=0.
REQ-027 The first OUT cycle SHALL present out_valid=1 and out_bit=x[0].
REQ-028 Latency: the first out_valid SHALL occur log2(N)+1 cycles after the last input handshake.
REQ-029 In OUT, j SHALL advance on out_valid&out_ready; while out_ready=0, out_bit and out_last SHALL hold stable and out_valid stays 1.
REQ-030 The handshake on j=N-1 (out_last=1) SHALL return the FSM to IDLE; out_valid=0 on the next cycle.
REQ-031 start arriving in the same cycle as the final output handshake SHALL be ignored; a new codeword requires start while in IDLE.
REQ-032 in_valid outside LOAD SHALL be ignored without side effects.
REQ-033 Throughput: at most one input bit and one output bit per cycle.

Reset
REQ-034 On rst_n=0, asynchronously and in any state, the block SHALL enter IDLE, clear all counters and buf, and drive in_ready=0, out_valid=0, out_bit=0, out_last=0, busy=0.
REQ-035 After rst_n rises, the block SHALL wait for a fresh start; any partial codeword is discarded.

Verification
REQ-036 The bench SHALL cover: N=128, all 128 positions frozen with in_bit=1 -> 128 outputs all 0, out_last only on the 128th bit, first out_valid 8 cycles after the last input.
REQ-037 The bench SHALL cover: N=512, u[511]=1, all others 0, none frozen -> all 512 outputs 1.
REQ-038 The bench SHALL cover: N=256, u[0]=1 only -> x[0]=1 and x[1..255]=0; then u[1]=1 only -> x[0]=1, x[1]=1, rest 0.
REQ-039 The bench SHALL cover: N=128 random u with a random frozen mask, out_ready toggled randomly -> output matches a reference u·F^{⊗7}, out_bit stable while stalled, exactly 128 handshakes.
REQ-040 The bench SHALL cover: start with n_sel=3 -> busy stays 0; start during ENC -> ignored and the codeword is unaffected.
REQ-041 The bench SHALL cover: rst_n pulsed low mid-ENC -> all outputs 0 immediately, IDLE; the next N=128 run with u[127]=1 yields all ones.
